// File: rtl/riscv_pkg.sv
// Shared widths and ALU opcode encodings for the integer pipeline.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int OP_W       = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_op_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand bypass selector: picks the youngest in-flight result for a source register.
module fwd_mux #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [XLEN-1:0]       stored_data,
  input  logic [REG_ADDR_W-1:0] exm_rd,
  input  logic                  exm_reg_write,
  input  logic [XLEN-1:0]       exm_result,
  input  logic [REG_ADDR_W-1:0] mwb_rd,
  input  logic                  mwb_reg_write,
  input  logic [XLEN-1:0]       mwb_result,
  output logic [XLEN-1:0]       operand
);

  import riscv_pkg::*;

  // x0 is hardwired, so it never takes a bypass; EX/MEM is younger than MEM/WB and wins.
  always_comb begin
    operand = stored_data;
    if (rs_addr != '0) begin
      if (exm_reg_write && (exm_rd == rs_addr)) begin
        operand = exm_result;
      end else if (mwb_reg_write && (mwb_rd == rs_addr)) begin
        operand = mwb_result;
      end
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// One-entry ID/EX register with operand forwarding and valid/ready handshakes.
// Define ID_EX_STAT_EN to add saturating issue/stall counters (stat_issued, stat_stall).
module id_ex_stage #(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W,
  parameter int OP_W       = riscv_pkg::OP_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr,
  input  logic [XLEN-1:0]       in_rs1_data,
  input  logic [XLEN-1:0]       in_rs2_data,
  input  logic [XLEN-1:0]       in_imm,
  input  logic                  in_use_imm,
  input  logic [OP_W-1:0]       in_alu_op,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_reg_write,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] exm_rd,
  input  logic                  exm_reg_write,
  input  logic [XLEN-1:0]       exm_result,
  input  logic [REG_ADDR_W-1:0] mwb_rd,
  input  logic                  mwb_reg_write,
  input  logic [XLEN-1:0]       mwb_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_a,
  output logic [XLEN-1:0]       out_b,
  output logic [OP_W-1:0]       out_alu_op,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write
`ifdef ID_EX_STAT_EN
  ,
  output logic [31:0]           stat_issued,
  output logic [31:0]           stat_stall
`endif
);

  import riscv_pkg::*;

  logic                  held_valid;
  logic [REG_ADDR_W-1:0] rs1_addr_q;
  logic [REG_ADDR_W-1:0] rs2_addr_q;
  logic [XLEN-1:0]       rs1_data_q;
  logic [XLEN-1:0]       rs2_data_q;
  logic [XLEN-1:0]       imm_q;
  logic                  use_imm_q;
  logic [OP_W-1:0]       alu_op_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  reg_write_q;

  logic                  accept;
  logic                  transfer;
  logic                  stall;
  logic                  cap_hit1;
  logic                  cap_hit2;
  logic                  hold_hit1;
  logic                  hold_hit2;
  logic [XLEN-1:0]       rs1_fwd;
  logic [XLEN-1:0]       rs2_fwd;

  assign in_ready = !held_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign transfer = held_valid && out_ready;
  assign stall    = held_valid && !out_ready;

  // A MEM/WB write is also the regfile write, so the stored copy must track it.
  assign cap_hit1  = mwb_reg_write && (mwb_rd != '0) && (mwb_rd == in_rs1_addr);
  assign cap_hit2  = mwb_reg_write && (mwb_rd != '0) && (mwb_rd == in_rs2_addr);
  assign hold_hit1 = mwb_reg_write && (mwb_rd != '0) && (mwb_rd == rs1_addr_q);
  assign hold_hit2 = mwb_reg_write && (mwb_rd != '0) && (mwb_rd == rs2_addr_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      held_valid  <= 1'b0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      use_imm_q   <= 1'b0;
      alu_op_q    <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
    end else if (flush) begin
      held_valid <= 1'b0;
    end else if (accept) begin
      held_valid  <= 1'b1;
      rs1_addr_q  <= in_rs1_addr;
      rs2_addr_q  <= in_rs2_addr;
      rs1_data_q  <= cap_hit1 ? mwb_result : in_rs1_data;
      rs2_data_q  <= cap_hit2 ? mwb_result : in_rs2_data;
      imm_q       <= in_imm;
      use_imm_q   <= in_use_imm;
      alu_op_q    <= in_alu_op;
      rd_q        <= in_rd;
      reg_write_q <= in_reg_write;
    end else if (transfer) begin
      held_valid <= 1'b0;
    end else if (stall) begin
      if (hold_hit1) rs1_data_q <= mwb_result;
      if (hold_hit2) rs2_data_q <= mwb_result;
    end
  end

  fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .rs_addr       (rs1_addr_q),
    .stored_data   (rs1_data_q),
    .exm_rd        (exm_rd),
    .exm_reg_write (exm_reg_write),
    .exm_result    (exm_result),
    .mwb_rd        (mwb_rd),
    .mwb_reg_write (mwb_reg_write),
    .mwb_result    (mwb_result),
    .operand       (rs1_fwd)
  );

  fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .rs_addr       (rs2_addr_q),
    .stored_data   (rs2_data_q),
    .exm_rd        (exm_rd),
    .exm_reg_write (exm_reg_write),
    .exm_result    (exm_result),
    .mwb_rd        (mwb_rd),
    .mwb_reg_write (mwb_reg_write),
    .mwb_result    (mwb_result),
    .operand       (rs2_fwd)
  );

  assign out_valid     = held_valid;
  assign out_a         = rs1_fwd;
  assign out_b         = use_imm_q ? imm_q : rs2_fwd;
  assign out_alu_op    = alu_op_q;
  assign out_rd        = rd_q;
  assign out_reg_write = reg_write_q && held_valid;

`ifdef ID_EX_STAT_EN
  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (transfer && (stat_issued != 32'hFFFF_FFFF)) stat_issued <= stat_issued + 32'd1;
      if (stall && (stat_stall != 32'hFFFF_FFFF))     stat_stall  <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios then random traffic vs a reference model.
module tb_id_ex_stage;

  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1_addr;
  logic [4:0]  in_rs2_addr;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic [31:0] in_imm;
  logic        in_use_imm;
  logic [3:0]  in_alu_op;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        flush;
  logic [4:0]  exm_rd;
  logic        exm_reg_write;
  logic [31:0] exm_result;
  logic [4:0]  mwb_rd;
  logic        mwb_reg_write;
  logic [31:0] mwb_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rd;
  logic        out_reg_write;
`ifdef ID_EX_STAT_EN
  logic [31:0] stat_issued;
  logic [31:0] stat_stall;
`endif

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rs1_addr   (in_rs1_addr),
    .in_rs2_addr   (in_rs2_addr),
    .in_rs1_data   (in_rs1_data),
    .in_rs2_data   (in_rs2_data),
    .in_imm        (in_imm),
    .in_use_imm    (in_use_imm),
    .in_alu_op     (in_alu_op),
    .in_rd         (in_rd),
    .in_reg_write  (in_reg_write),
    .flush         (flush),
    .exm_rd        (exm_rd),
    .exm_reg_write (exm_reg_write),
    .exm_result    (exm_result),
    .mwb_rd        (mwb_rd),
    .mwb_reg_write (mwb_reg_write),
    .mwb_result    (mwb_result),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_a         (out_a),
    .out_b         (out_b),
    .out_alu_op    (out_alu_op),
    .out_rd        (out_rd),
    .out_reg_write (out_reg_write)
`ifdef ID_EX_STAT_EN
    ,
    .stat_issued   (stat_issued),
    .stat_stall    (stat_stall)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: the instruction sitting in the stage, with its operand values as
  // the register file would currently report them.
  bit          m_known = 1'b0;
  bit          m_valid;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_v1, m_v2, m_imm;
  bit          m_use_imm, m_we;
  logic [3:0]  m_op;
  longint      m_issued, m_stall;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] bypassed(input logic [4:0] rs, input logic [31:0] held);
    if (rs == 5'd0) return held;
    if (exm_reg_write && exm_rd == rs) return exm_result;
    if (mwb_reg_write && mwb_rd == rs) return mwb_result;
    return held;
  endfunction

  function automatic logic [31:0] regfileView(input logic [4:0] rs, input logic [31:0] old);
    return (mwb_reg_write && mwb_rd != 5'd0 && mwb_rd == rs) ? mwb_result : old;
  endfunction

  task automatic modelCompare();
    if (!m_known) return;
    checkOutput("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
    checkOutput("out_reg_write", 32'(out_reg_write), 32'(m_valid && m_we));
    if (m_valid) begin
      checkOutput("out_a", out_a, bypassed(m_rs1, m_v1));
      checkOutput("out_b", out_b, m_use_imm ? m_imm : bypassed(m_rs2, m_v2));
      checkOutput("out_alu_op", 32'(out_alu_op), 32'(m_op));
      checkOutput("out_rd", 32'(out_rd), 32'(m_rd));
    end
`ifdef ID_EX_STAT_EN
    checkOutput("stat_issued", stat_issued, 32'(m_issued));
    checkOutput("stat_stall", stat_stall, 32'(m_stall));
`endif
  endtask

  task automatic modelAdvance();
    bit can_take, leaves, waits;
    if (rst) begin
      m_known = 1'b1; m_valid = 1'b0;
      m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_v1 = '0; m_v2 = '0; m_imm = '0;
      m_use_imm = 1'b0; m_we = 1'b0; m_op = '0; m_issued = 0; m_stall = 0;
      return;
    end
    can_take = !m_valid || out_ready;
    leaves   = m_valid && out_ready;
    waits    = m_valid && !out_ready;
    if (leaves && m_issued < 64'hFFFF_FFFF) m_issued++;
    if (waits && m_stall < 64'hFFFF_FFFF) m_stall++;
    if (waits) begin
      m_v1 = regfileView(m_rs1, m_v1);
      m_v2 = regfileView(m_rs2, m_v2);
    end
    if (flush) begin
      m_valid = 1'b0;
    end else if (in_valid && can_take) begin
      m_valid = 1'b1;
      m_rs1 = in_rs1_addr; m_rs2 = in_rs2_addr;
      m_v1 = regfileView(in_rs1_addr, in_rs1_data);
      m_v2 = regfileView(in_rs2_addr, in_rs2_data);
      m_imm = in_imm; m_use_imm = in_use_imm; m_op = in_alu_op;
      m_rd = in_rd; m_we = in_reg_write;
    end else if (leaves) begin
      m_valid = 1'b0;
    end
  endtask

  // One clock: compare during the low phase, then let the edge happen and advance the model.
  task automatic applyStimulus();
    @(negedge clk);
    #2;
    modelCompare();
    @(posedge clk);
    modelAdvance();
    #1;
  endtask

  task automatic setIdle();
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_rs1_addr = '0; in_rs2_addr = '0; in_rs1_data = '0; in_rs2_data = '0;
    in_imm = '0; in_use_imm = 1'b0; in_alu_op = '0; in_rd = '0; in_reg_write = 1'b0;
    exm_rd = '0; exm_reg_write = 1'b0; exm_result = '0;
    mwb_rd = '0; mwb_reg_write = 1'b0; mwb_result = '0;
  endtask

  task automatic setInstr(input logic [4:0] r1, input logic [31:0] d1, input logic [4:0] r2,
                          input logic [31:0] d2, input logic [31:0] imm, input logic ui,
                          input logic [3:0] op, input logic [4:0] rd, input logic we);
    in_valid = 1'b1;
    in_rs1_addr = r1; in_rs1_data = d1; in_rs2_addr = r2; in_rs2_data = d2;
    in_imm = imm; in_use_imm = ui; in_alu_op = op; in_rd = rd; in_reg_write = we;
  endtask

  initial begin
    setIdle();
    rst = 1'b1;
    applyStimulus();
    applyStimulus();
    rst = 1'b0;
    #1;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_out_reg_write", 32'(out_reg_write), 32'd0);

    $display("[TB] basic capture");
    setInstr(5'd1, 32'd5, 5'd2, 32'd9, 32'd7, 1'b1, ALU_ADD, 5'd4, 1'b1);
    applyStimulus();
    in_valid = 1'b0;
    #1;
    checkOutput("cap_valid", 32'(out_valid), 32'd1);
    checkOutput("cap_a", out_a, 32'd5);
    checkOutput("cap_b", out_b, 32'd7);
    checkOutput("cap_op", 32'(out_alu_op), 32'(ALU_ADD));
    checkOutput("cap_rd", 32'(out_rd), 32'd4);
    applyStimulus();

    $display("[TB] forwarding priority");
    setInstr(5'd3, 32'h1111, 5'd0, 32'd0, 32'd0, 1'b0, ALU_OR, 5'd7, 1'b1);
    applyStimulus();
    in_valid = 1'b0; out_ready = 1'b0;
    exm_rd = 5'd3; exm_reg_write = 1'b1; exm_result = 32'hAAAA;
    mwb_rd = 5'd3; mwb_reg_write = 1'b1; mwb_result = 32'hBBBB;
    #1;
    checkOutput("fwd_exm_wins", out_a, 32'hAAAA);
    applyStimulus();
    exm_reg_write = 1'b0;
    #1;
    checkOutput("fwd_mwb", out_a, 32'hBBBB);
    applyStimulus();
    setInstr(5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, ALU_XOR, 5'd8, 1'b1);
    out_ready = 1'b1;
    exm_rd = 5'd0; exm_reg_write = 1'b1; exm_result = 32'hDEAD;
    mwb_rd = 5'd0; mwb_reg_write = 1'b1; mwb_result = 32'hBEEF;
    applyStimulus();
    #1;
    checkOutput("fwd_x0", out_a, 32'd0);
    setIdle();
    applyStimulus();

    $display("[TB] stall with writeback snoop");
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    setInstr(5'd3, 32'd0, 5'd5, 32'h55, 32'd0, 1'b0, ALU_SUB, 5'd6, 1'b1);
    applyStimulus();
    setInstr(5'd1, 32'd1, 5'd1, 32'd1, 32'd1, 1'b1, ALU_AND, 5'd9, 1'b1);
    out_ready = 1'b0;
    #1;
    checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
    applyStimulus();
    mwb_rd = 5'd3; mwb_reg_write = 1'b1; mwb_result = 32'h1234;
    applyStimulus();
    mwb_reg_write = 1'b0;
    #1;
    checkOutput("stall_snooped_a", out_a, 32'h1234);
    checkOutput("stall_held_rd", 32'(out_rd), 32'd6);
    applyStimulus();
    in_valid = 1'b0; out_ready = 1'b1;
    applyStimulus();
    #1;
    checkOutput("stall_drained", 32'(out_valid), 32'd0);
`ifdef ID_EX_STAT_EN
    checkOutput("stall_stat_stall", stat_stall, 32'd3);
    checkOutput("stall_stat_issued", stat_issued, 32'd1);
`endif

    $display("[TB] back-to-back stream");
    for (int i = 1; i <= 8; i++) begin
      setInstr(5'd1, 32'(i), 5'd2, 32'd0, 32'(i * 16), 1'b1, ALU_ADD, 5'(i), 1'b1);
      applyStimulus();
      #1;
      checkOutput($sformatf("stream_valid_%0d", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("stream_rd_%0d", i), 32'(out_rd), 32'(i));
      checkOutput($sformatf("stream_b_%0d", i), out_b, 32'(i * 16));
    end

    $display("[TB] flush and mid-stall reset");
    out_ready = 1'b0; flush = 1'b1;
    setInstr(5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 1'b0, ALU_SLT, 5'd9, 1'b1);
    applyStimulus();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checkOutput("flush_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
    setInstr(5'd2, 32'd2, 5'd3, 32'd3, 32'd0, 1'b0, ALU_SRA, 5'd10, 1'b1);
    applyStimulus();
    in_valid = 1'b0;
    applyStimulus();
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    #1;
    checkOutput("rst_hold_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_hold_reg_write", 32'(out_reg_write), 32'd0);
`ifdef ID_EX_STAT_EN
    checkOutput("rst_stat_issued", stat_issued, 32'd0);
    checkOutput("rst_stat_stall", stat_stall, 32'd0);
`endif

    $display("[TB] random traffic");
    setIdle();
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 99) == 0);
      flush         = ($urandom_range(0, 19) == 0);
      in_valid      = $urandom_range(0, 1) == 1;
      out_ready     = ($urandom_range(0, 3) != 0);
      in_rs1_addr   = 5'($urandom_range(0, 3));
      in_rs2_addr   = 5'($urandom_range(0, 3));
      in_rs1_data   = $urandom;
      in_rs2_data   = $urandom;
      in_imm        = $urandom;
      in_use_imm    = $urandom_range(0, 1) == 1;
      in_alu_op     = 4'($urandom_range(0, 9));
      in_rd         = 5'($urandom_range(0, 31));
      in_reg_write  = $urandom_range(0, 1) == 1;
      exm_rd        = 5'($urandom_range(0, 3));
      exm_reg_write = $urandom_range(0, 1) == 1;
      exm_result    = $urandom;
      mwb_rd        = 5'($urandom_range(0, 3));
      mwb_reg_write = $urandom_range(0, 1) == 1;
      mwb_result    = $urandom;
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
